// File: rtl/apb3_rr_arbiter_if.sv
// Requester and APB3 completer signals shared by the two-requester arbiter.
// master = arbiter side, slave = requesters plus APB completer side.
interface apb3_rr_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              REQ0, REQ1;
    logic              WR0, WR1;
    logic [ADDR_W-1:0] ADDR0, ADDR1;
    logic [DATA_W-1:0] WDATA0, WDATA1;
    logic              ACK0, ACK1;
    logic [DATA_W-1:0] RDATA0, RDATA1;
    logic              ERR0, ERR1;

    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PSEL, PENABLE, PWRITE;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY, PSLVERR;

    logic [1:0]        GNT;
    logic              BUSY;

    modport master (
        input  REQ0, REQ1, WR0, WR1, ADDR0, ADDR1, WDATA0, WDATA1,
        input  PRDATA, PREADY, PSLVERR,
        output ACK0, ACK1, RDATA0, RDATA1, ERR0, ERR1,
        output PADDR, PWDATA, PSEL, PENABLE, PWRITE, GNT, BUSY
    );

    modport slave (
        output REQ0, REQ1, WR0, WR1, ADDR0, ADDR1, WDATA0, WDATA1,
        output PRDATA, PREADY, PSLVERR,
        input  ACK0, ACK1, RDATA0, RDATA1, ERR0, ERR1,
        input  PADDR, PWDATA, PSEL, PENABLE, PWRITE, GNT, BUSY
    );
endinterface

// File: rtl/apb3_rr_arbiter.sv
// Round-robin APB3 master shared by two transaction-level requesters,
// with a PREADY watchdog so a stuck completer cannot hang either sequencer.

// Per-requester completion registers: ACK pulse plus held RDATA/ERR.
module apb3_rr_arbiter_rsp #(
    parameter int DATA_W = 8
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              fin_i,
    input  logic              tmo_i,
    input  logic              rd_i,
    input  logic              slverr_i,
    input  logic [DATA_W-1:0] prdata_i,
    output logic              ack_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o
);
    logic              ack_q, err_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= fin_i;
            if (fin_i) begin
                err_q <= tmo_i | slverr_i;
                // A timed-out transfer returns zero; a completed write leaves RDATA alone.
                if (tmo_i)     rdata_q <= '0;
                else if (rd_i) rdata_q <= prdata_i;
            end
        end
    end

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
endmodule

module apb3_rr_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                PCLK,
    input  logic                PRESETN,
    apb3_rr_arbiter_if.master   bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [7:0] TO_W = 8'(TIMEOUT);

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic              last_q;
    logic [1:0]        gnt_q;
    logic              psel_q, penable_q, pwrite_q, busy_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;

    logic [1:0]              req;
    logic [1:0]              wr;
    logic [1:0][ADDR_W-1:0]  addr;
    logic [1:0][DATA_W-1:0]  wdata;
    logic                    win;
    logic [7:0]              cnt_inc;
    logic                    fin;

    assign req   = {bus.REQ1, bus.REQ0};
    assign wr    = {bus.WR1, bus.WR0};
    assign addr  = {bus.ADDR1, bus.ADDR0};
    assign wdata = {bus.WDATA1, bus.WDATA0};

    // On a tie the requester that did not win last time takes the bus.
    assign win     = (req == 2'b11) ? ~last_q : req[1];
    assign cnt_inc = cnt_q + 8'd1;
    assign fin     = (state_q == ACCESS) && (bus.PREADY || (cnt_inc == TO_W));

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            gnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            busy_q    <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q   <= SETUP;
                        gnt_q     <= win ? 2'b10 : 2'b01;
                        last_q    <= win;
                        paddr_q   <= addr[win];
                        pwdata_q  <= wdata[win];
                        pwrite_q  <= wr[win];
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end
                ACCESS: begin
                    if (!bus.PREADY) cnt_q <= cnt_inc;
                    if (fin) begin
                        state_q   <= DONE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    wire [1:0]             ack;
    wire [1:0]             err;
    wire [1:0][DATA_W-1:0] rdata;

    for (genvar i = 0; i < 2; i++) begin : g_lane
        apb3_rr_arbiter_rsp #(.DATA_W(DATA_W)) u_rsp (
            .PCLK     (PCLK),
            .PRESETN  (PRESETN),
            .fin_i    (fin && gnt_q[i]),
            .tmo_i    (!bus.PREADY),
            .rd_i     (!pwrite_q),
            .slverr_i (bus.PSLVERR),
            .prdata_i (bus.PRDATA),
            .ack_o    (ack[i]),
            .err_o    (err[i]),
            .rdata_o  (rdata[i])
        );
    end

    assign bus.ACK0    = ack[0];
    assign bus.ACK1    = ack[1];
    assign bus.ERR0    = err[0];
    assign bus.ERR1    = err[1];
    assign bus.RDATA0  = rdata[0];
    assign bus.RDATA1  = rdata[1];
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.GNT     = gnt_q;
    assign bus.BUSY    = busy_q;

    a_pen_sel: assert property (@(posedge PCLK) disable iff (!PRESETN) penable_q |-> psel_q);
    a_gnt_oh:  assert property (@(posedge PCLK) disable iff (!PRESETN) $onehot0(gnt_q));
    a_sel_gnt: assert property (@(posedge PCLK) disable iff (!PRESETN) psel_q |-> (gnt_q != 2'b00));
endmodule

// File: tb/tb_apb3_rr_arbiter.sv
// Randomized bench for apb3_rr_arbiter: a transaction-level model predicts the
// winner, ACK latency, bus contents and the per-requester RDATA/ERR.
module tb_apb3_rr_arbiter;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int TO = 4;

    logic PCLK = 1'b0;
    logic PRESETN = 1'b0;
    always #5 PCLK = ~PCLK;

    apb3_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb3_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: who won last, and what each requester should be showing.
    bit          last_m;
    logic [DW-1:0] rd_m [2];
    bit          er_m [2];

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic model_reset();
        last_m = 1'b1;
        rd_m[0] = '0; rd_m[1] = '0;
        er_m[0] = 1'b0; er_m[1] = 1'b0;
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.ACK0, bus.ACK1, bus.ERR0, bus.ERR1, bus.RDATA0, bus.RDATA1,
                    bus.PADDR, bus.PWDATA, bus.PSEL, bus.PENABLE, bus.PWRITE,
                    bus.GNT, bus.BUSY});
    endfunction

    task automatic set_req(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (r == 0) begin
            bus.REQ0 = 1'b1; bus.WR0 = wr; bus.ADDR0 = a; bus.WDATA0 = d;
        end else begin
            bus.REQ1 = 1'b1; bus.WR1 = wr; bus.ADDR1 = a; bus.WDATA1 = d;
        end
    endtask

    // Runs one transfer starting in IDLE with the requests already driven.
    // waits = PREADY-low ACCESS cycles the completer inserts before answering.
    task automatic xfer(input int waits, input bit slverr, input logic [DW-1:0] prd,
                        input bit scramble, output int who);
        bit [1:0] rq;
        int w, n, acc, exp_lat;
        bit wr, tmo;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0] eg;
        rq = {bus.REQ1, bus.REQ0};
        w = (rq == 2'b11) ? (last_m ? 0 : 1) : (rq[1] ? 1 : 0);
        last_m = (w == 1);
        who = w;
        a  = (w == 0) ? bus.ADDR0  : bus.ADDR1;
        d  = (w == 0) ? bus.WDATA0 : bus.WDATA1;
        wr = (w == 0) ? bus.WR0    : bus.WR1;
        eg = (w == 0) ? 2'b01 : 2'b10;
        tmo = (waits >= TO);
        exp_lat = tmo ? 2 + TO : 3 + waits;
        n = 0; acc = 0;
        bus.PREADY = 1'b0;
        while (n < 300) begin
            tick();
            n++;
            if (bus.ACK0 === 1'b1 || bus.ACK1 === 1'b1) break;
            checks++;
            if (bus.GNT !== eg || bus.BUSY !== 1'b1 || bus.PSEL !== 1'b1 ||
                bus.PENABLE !== (n >= 2) || bus.PADDR !== a || bus.PWRITE !== wr ||
                (wr && bus.PWDATA !== d)) begin
                errors++;
                $display("FAIL bus_phase cyc=%0d: gnt=%b busy=%b psel=%b pen=%b paddr=%h pwrite=%b pwdata=%h, want gnt=%b pen=%b paddr=%h pwrite=%b pwdata=%h",
                         n, bus.GNT, bus.BUSY, bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE,
                         bus.PWDATA, eg, (n >= 2), a, wr, d);
            end
            if (scramble) begin
                if (w == 0) begin
                    bus.ADDR0 = AW'($urandom); bus.WDATA0 = DW'($urandom); bus.WR0 = 1'($urandom);
                end else begin
                    bus.ADDR1 = AW'($urandom); bus.WDATA1 = DW'($urandom); bus.WR1 = 1'($urandom);
                end
            end
            if (bus.PENABLE === 1'b1) begin
                acc++;
                bus.PREADY  = (acc > waits);
                bus.PSLVERR = (acc > waits) ? slverr : 1'($urandom);
                bus.PRDATA  = (acc > waits) ? prd : DW'($urandom);
            end
        end
        checks++;
        if (n !== exp_lat) begin
            errors++;
            $display("FAIL ack_latency: got %0d cycles, want %0d (req=%0d waits=%0d)", n, exp_lat, w, waits);
        end
        if (tmo) begin
            rd_m[w] = '0; er_m[w] = 1'b1;
        end else begin
            er_m[w] = slverr;
            if (!wr) rd_m[w] = prd;
        end
        checks++;
        if ({bus.ACK1, bus.ACK0} !== eg || bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 ||
            bus.GNT !== eg || bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL done_phase: ack=%b psel=%b pen=%b gnt=%b busy=%b, want ack=%b psel=0 pen=0 gnt=%b busy=1",
                     {bus.ACK1, bus.ACK0}, bus.PSEL, bus.PENABLE, bus.GNT, bus.BUSY, eg, eg);
        end
        checks++;
        if (bus.RDATA0 !== rd_m[0] || bus.RDATA1 !== rd_m[1] || bus.ERR0 !== er_m[0] || bus.ERR1 !== er_m[1]) begin
            errors++;
            $display("FAIL response: rdata0=%h rdata1=%h err0=%b err1=%b, want %h %h %b %b",
                     bus.RDATA0, bus.RDATA1, bus.ERR0, bus.ERR1, rd_m[0], rd_m[1], er_m[0], er_m[1]);
        end
        if (w == 0) bus.REQ0 = 1'b0; else bus.REQ1 = 1'b0;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        tick();
        checks++;
        if ({bus.ACK1, bus.ACK0, bus.GNT, bus.BUSY, bus.PSEL, bus.PENABLE} !== 7'b0 ||
            bus.RDATA0 !== rd_m[0] || bus.RDATA1 !== rd_m[1] || bus.ERR0 !== er_m[0] || bus.ERR1 !== er_m[1]) begin
            errors++;
            $display("FAIL idle_return: ack=%b gnt=%b busy=%b psel=%b pen=%b rdata=%h/%h err=%b/%b, want all zero, rdata=%h/%h err=%b/%b",
                     {bus.ACK1, bus.ACK0}, bus.GNT, bus.BUSY, bus.PSEL, bus.PENABLE,
                     bus.RDATA0, bus.RDATA1, bus.ERR0, bus.ERR1, rd_m[0], rd_m[1], er_m[0], er_m[1]);
        end
    endtask

    task automatic test_reset();
        bus.REQ0 = 1'b1; bus.WR0 = 1'b1; bus.ADDR0 = 9'h1FF; bus.WDATA0 = 8'hFF;
        PRESETN = 1'b0;
        tick(); tick();
        checks++;
        if (outs() !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0", outs());
        end
        bus.REQ0 = 1'b0;
        model_reset();
        PRESETN = 1'b1;
        tick(); tick();
        checks++;
        if (outs() !== 64'd0) begin
            errors++;
            $display("FAIL idle_no_req: got %h, want 0", outs());
        end
    endtask

    task automatic test_write();
        int who;
        set_req(0, 1'b1, 9'h00C, 8'h0B);
        xfer(0, 1'b0, 8'h3C, 1'b0, who);
        checks++;
        if (who !== 0) begin errors++; $display("FAIL write_owner: got %0d, want 0", who); end
    endtask

    task automatic test_read_wait();
        int who;
        set_req(1, 1'b0, 9'h004, 8'h00);
        xfer(3, 1'b0, 8'hA8, 1'b1, who);
        checks++;
        if (who !== 1 || bus.RDATA1 !== 8'hA8) begin
            errors++;
            $display("FAIL read_wait: owner=%0d rdata1=%h, want owner=1 rdata1=a8", who, bus.RDATA1);
        end
    endtask

    task automatic test_simultaneous();
        int who;
        set_req(0, 1'b0, 9'h010, 8'h00);
        set_req(1, 1'b1, 9'h020, 8'h77);
        for (int k = 0; k < 4; k++) begin
            xfer(0, 1'b0, DW'($urandom), 1'b0, who);
            checks++;
            if (who !== (k % 2)) begin
                errors++;
                $display("FAIL grant_order[%0d]: got %0d, want %0d", k, who, k % 2);
            end
            if (k < 2) set_req(who, 1'($urandom), AW'($urandom), DW'($urandom));
        end
    endtask

    task automatic test_pslverr();
        int who;
        set_req(0, 1'b0, 9'h0AA, 8'h00);
        xfer(0, 1'b1, 8'h55, 1'b0, who);
        checks++;
        if (bus.ERR0 !== 1'b1 || bus.RDATA0 !== 8'h55) begin
            errors++;
            $display("FAIL pslverr: err0=%b rdata0=%h, want 1 55", bus.ERR0, bus.RDATA0);
        end
    endtask

    task automatic test_timeout();
        int who;
        set_req(1, 1'b0, 9'h004, 8'h00);
        xfer(1000, 1'b0, 8'hEE, 1'b0, who);
        checks++;
        if (bus.ERR1 !== 1'b1 || bus.RDATA1 !== 8'h00) begin
            errors++;
            $display("FAIL timeout: err1=%b rdata1=%h, want 1 00", bus.ERR1, bus.RDATA1);
        end
        set_req(0, 1'b0, 9'h033, 8'h00);
        xfer(1, 1'b0, 8'h5A, 1'b0, who);
        checks++;
        if (who !== 0 || bus.ERR0 !== 1'b0 || bus.RDATA0 !== 8'h5A) begin
            errors++;
            $display("FAIL after_timeout: owner=%0d err0=%b rdata0=%h, want 0 0 5a", who, bus.ERR0, bus.RDATA0);
        end
    endtask

    task automatic test_random();
        int who;
        for (int k = 0; k < 30; k++) begin
            if (bus.REQ0 !== 1'b1 && $urandom_range(0, 1) == 1)
                set_req(0, 1'($urandom), AW'($urandom), DW'($urandom));
            if (bus.REQ1 !== 1'b1 && $urandom_range(0, 1) == 1)
                set_req(1, 1'($urandom), AW'($urandom), DW'($urandom));
            if (bus.REQ0 !== 1'b1 && bus.REQ1 !== 1'b1)
                set_req($urandom_range(0, 1), 1'($urandom), AW'($urandom), DW'($urandom));
            xfer($urandom_range(0, 5), 1'($urandom), DW'($urandom), 1'b1, who);
        end
        while (bus.REQ0 === 1'b1 || bus.REQ1 === 1'b1)
            xfer(0, 1'b0, DW'($urandom), 1'b0, who);
    endtask

    task automatic test_reset_mid();
        int who;
        set_req(0, 1'b0, 9'h010, 8'h00);
        bus.PREADY = 1'b0;
        tick(); tick();
        checks++;
        if (bus.PENABLE !== 1'b1 || bus.GNT !== 2'b01) begin
            errors++;
            $display("FAIL reach_access: pen=%b gnt=%b, want 1 01", bus.PENABLE, bus.GNT);
        end
        #2 PRESETN = 1'b0;
        #1;
        checks++;
        if (outs() !== 64'd0) begin
            errors++;
            $display("FAIL reset_async: got %h, want 0", outs());
        end
        tick();
        checks++;
        if (outs() !== 64'd0) begin
            errors++;
            $display("FAIL reset_no_ack: got %h, want 0", outs());
        end
        model_reset();
        set_req(1, 1'b1, 9'h055, 8'h66);
        PRESETN = 1'b1;
        xfer(0, 1'b0, 8'h12, 1'b0, who);
        checks++;
        if (who !== 0) begin errors++; $display("FAIL post_reset_tie: got %0d, want 0", who); end
        xfer(0, 1'b0, 8'h34, 1'b0, who);
    endtask

    initial begin
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0; bus.WR0 = 1'b0; bus.WR1 = 1'b0;
        bus.ADDR0 = '0; bus.ADDR1 = '0; bus.WDATA0 = '0; bus.WDATA1 = '0;
        bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        model_reset();
        test_reset();
        test_write();
        test_read_wait();
        test_simultaneous();
        test_pslverr();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/apb3_rr_arbiter.md
Name: apb3_rr_arbiter

Overview:
- Shares the single APB3 master port in front of the CoreI2C register file between two transaction-level requesters.
  - Requester 0: I2C slave sequencer.
  - Requester 1: INA220 polling sequencer.
- Round-robin arbitration; the block runs the APB3 SETUP/ACCESS phases itself, honours PREADY wait states and reports PSLVERR.
- A watchdog terminates hung transfers so the I2C sequencers can never deadlock the bus.

Parameters:
- ADDR_W, 9, APB address width.
- DATA_W, 8, APB data width.
- TIMEOUT, 255, maximum ACCESS cycles with PREADY low before forced termination (range 1..255).

Ports:
- PCLK  in  1  APB clock.
- PRESETN  in  1  reset, asynchronous, active-low.
- REQ0 / REQ1  in  1  transfer request; held high until the matching ACK.
- WR0 / WR1  in  1  1 = write, 0 = read.
- ADDR0 / ADDR1  in  ADDR_W  register address.
- WDATA0 / WDATA1  in  DATA_W  write data.
- ACK0 / ACK1  out  1  one-cycle completion pulse.
- RDATA0 / RDATA1  out  DATA_W  read data; valid while ACKn is high, then held.
- ERR0 / ERR1  out  1  error flag (PSLVERR or timeout); valid with ACKn, then held.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PRDATA  in  DATA_W  APB read data.
- PREADY, PSLVERR  in  1  APB completer response.
- GNT  out  2  one-hot owner of the current transfer; 00 when idle.
- BUSY  out  1  high in SETUP, ACCESS and DONE.

Behaviour:
- Reset (asynchronous, any state): every output is 0 (PADDR, PWDATA, PSEL, PENABLE, PWRITE, ACKn, RDATAn, ERRn, GNT, BUSY). State = IDLE, wait counter = 0, LAST = 1, so REQ0 wins the first tie. Any transfer in flight is abandoned with no ACK.
- State machine: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- IDLE:
  - No REQ: stay in IDLE.
  - Any REQn high at the clock edge: go to SETUP.
  - The winner's ADDR, WDATA and WR are latched into PADDR/PWDATA/PWRITE; PSEL=1, PENABLE=0.
  - GNT = winner; BUSY = 1.
  - PWDATA is latched for reads as well; its value is don't-care.
- Arbitration: only REQ0 → 0. Only REQ1 → 1. Both → the requester that is not LAST. LAST updates on grant.
- SETUP: always lasts exactly one cycle, then ACCESS with PENABLE=1. Wait counter cleared.
- ACCESS, PREADY=1 at the edge:
  - PSEL=0, PENABLE=0, go to DONE.
  - For the owner: ACKn=1, ERRn=PSLVERR, RDATAn=PRDATA on a read. On a write, RDATAn keeps its previous value.
- ACCESS, PREADY=0 at the edge:
  - Wait counter increments.
  - When the counter reaches TIMEOUT: PSEL=0, PENABLE=0, go to DONE, ACKn=1, ERRn=1, RDATAn=0.
- DONE:
  - ACKn is high for this single cycle; requests are not sampled.
  - The next edge goes to IDLE with ACKn=0, GNT=00, BUSY=0.
  - Requesters drop REQn on the edge that follows ACKn, so no re-grant is possible.
- Address and data stability: ADDRn/WDATAn/WRn changes after grant are ignored; the latched values drive the bus. A non-owner REQ asserted during a transfer waits and is arbitrated in the next IDLE.
- Timing:
  - Minimum cost per transfer is 4 cycles (IDLE, SETUP, ACCESS, DONE); each PREADY-low cycle adds 1.
  - Latency from REQ high (in IDLE) to ACK high is 3 cycles with zero wait states.
- RDATAn/ERRn of the non-owner never change.
- PSEL never asserts without a grant; PENABLE is only ever high in ACCESS.

Test Plan:
- Write path: REQ0=1, WR0=1, ADDR0=0x0C, WDATA0=0x0B, PREADY=1.
  - PSEL rises 1 cycle after REQ0, PENABLE 1 cycle later.
  - ACK0 pulses one cycle in DONE with ERR0=0.
  - GNT=01 throughout; ACK1 stays 0.
- Read with wait states: REQ1 read of 0x04, PREADY low 3 ACCESS cycles, then high with PRDATA=0xA8.
  - ACK1 arrives 6 cycles after REQ1, with RDATA1=0xA8 and ERR1=0.
  - PADDR is held at 0x04 throughout.
- Simultaneous requests: REQ0 and REQ1 held high for 4 transfers (each requester re-asserts after its ACK).
  - Grant order is 0, 1, 0, 1.
  - Each transfer is 4 cycles; no cycle has both GNT bits set.
- PSLVERR: REQ0 read, PREADY=1, PSLVERR=1, PRDATA=0x55 → ACK0 with ERR0=1, RDATA0=0x55.
- Timeout: TIMEOUT=4, REQ1 with PREADY stuck at 0.
  - After 4 ACCESS cycles: ACK1=1, ERR1=1, RDATA1=0, PSEL=0.
  - A subsequent REQ0 is granted normally.
- Reset mid-transfer: PRESETN low during ACCESS.
  - All outputs are 0 immediately, with no ACK.
  - After release, REQ0 and REQ1 together → REQ0 granted first.
